regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two write-back requesters: the ALU and the load/memory unit.
- Keeps a 32-entry pending-write scoreboard so decode can stall on source registers that are not yet written.
- Sits between the execute/memory stages and the register file; drives the file's reg_write, rd and write_data inputs.
- The register file keeps x0 hard-wired to zero; this block never issues writes to x0.

---
 rtl/rv_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/rv_scoreboard.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared widths and the write-back request type for the RV register-file write path.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles decode issue, both write-back requesters, the RF write port and source queries.
interface regfile_wb_arbiter_if;
    import rv_pkg::*;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;
    logic                  rf_reg_write;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_write_data;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;

    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output mem_valid, mem_rd, mem_data, input mem_ready,
        input  rf_reg_write, rf_rd, rf_write_data,
        output rs1, rs2, input rs1_busy, rs2_busy
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data, output alu_ready,
        input  mem_valid, mem_rd, mem_data, output mem_ready,
        output rf_reg_write, rf_rd, rf_write_data,
        input  rs1, rs2, output rs1_busy, rs2_busy
    );
endinterface

// File: rtl/rv_scoreboard.sv
// Pending-write busy vector: set on issue, clear on commit (set wins), x0 never busy.
// Queries are combinational from registered state; updates land on the next edge.
module rv_scoreboard
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_vld_i,
    input  logic [REG_ADDR_W-1:0] set_idx_i,
    input  logic                  clr_vld_i,
    input  logic [REG_ADDR_W-1:0] clr_idx_i,
    input  logic [REG_ADDR_W-1:0] rs1_idx_i,
    input  logic [REG_ADDR_W-1:0] rs2_idx_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) busy_d[clr_idx_i] = 1'b0;
        // A fresh issue to the committing register means a newer producer is in flight.
        if (set_vld_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_idx_i];
    assign rs2_busy_o = busy_q[rs2_idx_i];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load write-back onto the single RF write port; write appears 1 cycle after grant.
// Loser sees ready=0 and retries; mem is preferred until the ALU has lost MAX_STARVE contested cycles.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int MAX_STARVE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb
);
    localparam logic [1:0] STARVE_LIM = 2'(MAX_STARVE);

    logic [1:0]            starve_q, starve_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;
    logic                  force_alu, alu_gnt, mem_gnt;
    wb_req_t               alu_req, mem_req, sel_req;

    assign alu_req = '{rd: wb.alu_rd, data: wb.alu_data};
    assign mem_req = '{rd: wb.mem_rd, data: wb.mem_data};

    always_comb begin
        force_alu = (starve_q == STARVE_LIM);
        alu_gnt   = wb.alu_valid && (!wb.mem_valid || force_alu);
        mem_gnt   = wb.mem_valid && !(wb.alu_valid && force_alu);
        sel_req   = alu_gnt ? alu_req : mem_req;

        // rd==0 is still accepted so the requester retires, but never reaches the file.
        rf_we_d   = (alu_gnt || mem_gnt) && (sel_req.rd != '0);
        rf_rd_d   = rf_we_d ? sel_req.rd   : '0;
        rf_data_d = rf_we_d ? sel_req.data : '0;

        starve_d = starve_q;
        if (alu_gnt || !wb.alu_valid) starve_d = '0;
        else if (starve_q != STARVE_LIM) starve_d = starve_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign wb.alu_ready     = alu_gnt;
    assign wb.mem_ready     = mem_gnt;
    assign wb.rf_reg_write  = rf_we_q;
    assign wb.rf_rd         = rf_rd_q;
    assign wb.rf_write_data = rf_data_q;

    rv_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_vld_i  (wb.issue_valid && (wb.issue_rd != '0)),
        .set_idx_i  (wb.issue_rd),
        .clr_vld_i  (rf_we_q),
        .clr_idx_i  (rf_rd_q),
        .rs1_idx_i  (wb.rs1),
        .rs2_idx_i  (wb.rs2),
        .rs1_busy_o (wb.rs1_busy),
        .rs2_busy_o (wb.rs2_busy)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a reference model and expected-write queue.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if wb ();

    regfile_wb_arbiter #(.MAX_STARVE(2)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] mb;
    int          mst;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb.issue_valid = 1'b0;
        wb.issue_rd    = '0;
        wb.alu_valid   = 1'b0;
        wb.alu_rd      = '0;
        wb.alu_data    = '0;
        wb.mem_valid   = 1'b0;
        wb.mem_rd      = '0;
        wb.mem_data    = '0;
    endtask

    // One clock: check combinational outputs, advance the model, then check the registered write port.
    task automatic tick();
        logic        ea, em;
        logic [31:0] mbn;
        exp_t        e;
        @(negedge clk);
        ea = wb.alu_valid && (!wb.mem_valid || mst == 2);
        em = wb.mem_valid && !(wb.alu_valid && mst == 2);
        chk("alu_ready", 32'(wb.alu_ready), 32'(ea));
        chk("mem_ready", 32'(wb.mem_ready), 32'(em));
        chk("one_grant", 32'(wb.alu_ready && wb.mem_ready), 32'(0));
        chk("rs1_busy", 32'(wb.rs1_busy), 32'(mb[wb.rs1]));
        chk("rs2_busy", 32'(wb.rs2_busy), 32'(mb[wb.rs2]));
        if (rst) begin
            exp_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'd0});
            mb  = '0;
            mst = 0;
        end else begin
            if (ea) exp_q.push_back('{we: (wb.alu_rd != 0), rd: (wb.alu_rd != 0) ? wb.alu_rd : 5'd0,
                                      data: (wb.alu_rd != 0) ? wb.alu_data : 32'd0});
            else if (em) exp_q.push_back('{we: (wb.mem_rd != 0), rd: (wb.mem_rd != 0) ? wb.mem_rd : 5'd0,
                                           data: (wb.mem_rd != 0) ? wb.mem_data : 32'd0});
            else exp_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'd0});
            mbn = mb;
            if (cur.we) mbn[cur.rd] = 1'b0;
            if (wb.issue_valid && wb.issue_rd != 0) mbn[wb.issue_rd] = 1'b1;
            mbn[0] = 1'b0;
            mb = mbn;
            if (ea || !wb.alu_valid) mst = 0;
            else if (mst < 2) mst = mst + 1;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'(1), 32'(0));
            cur = '{we: 1'b0, rd: 5'd0, data: 32'd0};
        end else begin
            e = exp_q.pop_front();
            chk("rf_reg_write", 32'(wb.rf_reg_write), 32'(e.we));
            chk("rf_rd", 32'(wb.rf_rd), 32'(e.rd));
            chk("rf_write_data", wb.rf_write_data, e.data);
            cur = e;
        end
    endtask

    initial begin
        logic [5:0] seq;
        idle();
        wb.rs1 = '0;
        wb.rs2 = '0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mb  = '0;
        mst = 0;
        cur = '{we: 1'b0, rd: 5'd0, data: 32'd0};

        // Reset state: every register idle, no write, no readies.
        for (int i = 0; i < 16; i++) begin
            wb.rs1 = 5'(i);
            wb.rs2 = 5'(i + 16);
            tick();
        end

        // Single ALU write: 1-cycle latency, 1-cycle pulse.
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
        tick();
        idle();
        tick();
        chk("alu5_write_seen", 32'(wb.rf_reg_write), 32'(0));
        tick();

        // Continuous contention: mem, mem, alu, mem, mem, alu.
        seq = 6'b100100;
        for (int k = 0; k < 6; k++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'hA000_0000 + 32'(k);
            wb.mem_valid = 1'b1; wb.mem_rd = 5'd4; wb.mem_data = 32'hB000_0000 + 32'(k);
            #2;
            chk("contend_alu_gnt", 32'(wb.alu_ready), 32'(seq[k]));
            tick();
        end
        idle();
        tick();
        tick();

        // Scoreboard: busy from issue until the cycle after commit.
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
        wb.rs1 = 5'd7; wb.rs2 = 5'd0;
        tick();
        wb.issue_valid = 1'b0;
        tick();
        chk("rs1_busy_r7", 32'(wb.rs1_busy), 32'(1));
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h0000_0077;
        tick();
        idle();
        chk("r7_commit_still_busy", 32'(wb.rs1_busy), 32'(1));
        tick();
        chk("r7_free_after_commit", 32'(wb.rs1_busy), 32'(0));
        chk("rs2_x0_never_busy", 32'(wb.rs2_busy), 32'(0));
        tick();

        // Issue and commit of the same register in one cycle: stays busy.
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd9; wb.rs1 = 5'd9;
        tick();
        wb.issue_valid = 1'b0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h0000_0099;
        tick();
        idle();
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd9;
        tick();
        idle();
        tick();
        chk("r9_set_wins", 32'(wb.rs1_busy), 32'(1));
        tick();

        // Load to x0: accepted, never written, scoreboard untouched.
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd0; wb.mem_data = 32'h0000_1234;
        tick();
        idle();
        chk("x0_no_write", 32'(wb.rf_reg_write), 32'(0));
        tick();
        chk("r9_unchanged", 32'(wb.rs1_busy), 32'(1));
        tick();

        // Reset while an ALU write to x6 is being granted.
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd12; wb.rs2 = 5'd12;
        tick();
        idle();
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h3333_0000;
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd4; wb.mem_data = 32'h4444_0000;
        tick();
        wb.mem_valid = 1'b0;
        wb.alu_rd = 5'd6; wb.alu_data = 32'h6666_6666;
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd13;
        rst = 1'b1;
        tick();
        chk("x6_dropped", 32'(wb.rf_reg_write), 32'(0));
        rst = 1'b0;
        idle();
        tick();
        chk("busy9_cleared", 32'(wb.rs1_busy), 32'(0));
        chk("busy12_cleared", 32'(wb.rs2_busy), 32'(0));
        wb.rs1 = 5'd13;
        tick();
        chk("busy13_cleared", 32'(wb.rs1_busy), 32'(0));

        // Starvation counter restarts from zero after reset.
        seq = 6'b000100;
        for (int k = 0; k < 3; k++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'hC000_0000 + 32'(k);
            wb.mem_valid = 1'b1; wb.mem_rd = 5'd4; wb.mem_data = 32'hD000_0000 + 32'(k);
            #2;
            chk("post_rst_alu_gnt", 32'(wb.alu_ready), 32'(seq[k]));
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
